// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud timing constants.
package uart_pkg;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned BAUD_DIV      = 1302;
  localparam int unsigned HALF_BAUD     = 650;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for the asynchronous rxd line; resets to idle-high.
module rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // Reset to all-ones so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '1;
    end else begin
      ff <= SYNC_STAGES'({ff, d});
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, mid-bit sampling and stop-bit
// checking, paced by half/done strobes from an external baud counter.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  input  logic                 half_pulse,
  input  logic                 done_pulse,
  output logic                 baud_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_e            state;
  logic                 rxd_s;
  logic                 rxd_d;
  logic                 fall_c;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;

  rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rxd),
    .q    (rxd_s)
  );

  // Edge needs a seen-high previous sample, so a held-low break cannot retrigger.
  assign fall_c = rxd_d & ~rxd_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_clr  <= 1'b1;
      busy      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
      rxd_d     <= 1'b1;
    end else begin
      rxd_d     <= rxd_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_c) begin
            state    <= START;
            baud_clr <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (half_pulse) begin
            if (rxd_s) begin
              state    <= IDLE;
              baud_clr <= 1'b1;
              busy     <= 1'b0;
            end
          end else if (done_pulse) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          // Right shift so the first bit received ends up at bit 0.
          if (half_pulse) begin
            shreg <= DATA_BITS'({rxd_s, shreg} >> 1);
          end else if (done_pulse) begin
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start bit is not missed.
          if (half_pulse) begin
            state    <= IDLE;
            baud_clr <= 1'b1;
            busy     <= 1'b0;
            if (rxd_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          baud_clr <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with a behavioural baud counter and a pulse scoreboard.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned BIT = BAUD_DIV;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       half_pulse;
  logic       done_pulse;
  logic       baud_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  logic [10:0] cnt = '0;
  exp_t        sb[$];
  logic [7:0]  last_good = 8'h00;
  int          n_vec = 0;
  int          n_bad = 0;

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (baud_clr) cnt <= '0;
    else if (cnt == 11'(BAUD_DIV - 1)) cnt <= '0;
    else cnt <= cnt + 11'd1;
  end
  assign half_pulse = (cnt == 11'(HALF_BAUD));
  assign done_pulse = (cnt == 11'(BAUD_DIV - 1));

  uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .half_pulse(half_pulse),
    .done_pulse(done_pulse),
    .baud_clr  (baud_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one expectation per output pulse.
  always @(posedge clk) begin
    #1;
    if (!reset && (rx_valid || frame_err)) begin
      check("valid_err_exclusive", 32'(rx_valid & frame_err), 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%0h expected none",
                 rx_valid, frame_err, rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", 32'({rx_valid, frame_err}), e.err ? 32'd1 : 32'd2);
        check("rx_data", 32'(rx_data), 32'(e.data));
      end
    end
  end

  // Drive a frame from the current negedge; line is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_bit);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    check("busy_in_frame", 32'(busy), 32'd1);
    check("baud_clr_in_frame", 32'(baud_clr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      if (i == abort_bit) begin
        repeat (BIT / 2) @(negedge clk);
        return;
      end
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.err  = ~stop;
    e.data = stop ? d : last_good;
    if (stop) last_good = d;
    sb.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_baud_clr"}, 32'(baud_clr), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rx_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_idle_outputs("post_reset");

    // Single good frame
    expect_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, -1);
    repeat (2 * BIT) @(negedge clk);

    // Back-to-back frames, second start right after the stop bit
    expect_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1, -1);
    expect_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1, -1);
    repeat (2 * BIT) @(negedge clk);
    check("after_b2b_rx_data", 32'(rx_data), 32'hFF);

    // Bad stop bit, then line held low (break) must not retrigger
    expect_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, -1);
    repeat (3 * BIT) @(negedge clk);
    check_idle_outputs("break");
    check("ferr_keeps_rx_data", 32'(rx_data), 32'hFF);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);

    // Start-bit glitch
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    check_idle_outputs("glitch");

    // Reset in the middle of data bit 4 of 0x55
    send_frame(8'h55, 1'b1, 4);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midframe_reset");
    check("midframe_reset_rx_data", 32'(rx_data), 32'd0);
    last_good = 8'h00;
    reset = 1'b0;
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1, -1);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    check("final_rx_data", 32'(rx_data), 32'h81);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (LSB first).
REQ-002 Parameter SYNC_STAGES, default 2, number of flip-flops in the rxd synchroniser.
REQ-003 The block SHALL have these ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  reset, synchronous, active-high.
- rxd  input  1  asynchronous serial line, idle high.
- half_pulse  input  1  one-cycle strobe from the baud counter at mid-bit (count 650).
- done_pulse  input  1  one-cycle strobe from the baud counter at end-of-bit (count 1301).
- baud_clr  output  1  held high to keep the baud counter at 0; low while a frame is in progress.
- rx_data  output  DATA_BITS  last correctly framed byte.
- rx_valid  output  1  one-cycle pulse, rx_data updated.
- frame_err  output  1  one-cycle pulse, stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

Function
REQ-004 rxd SHALL pass through a SYNC_STAGES flip-flop synchroniser; the FSM uses only the synchronised value rxd_s and its one-cycle-delayed copy.
REQ-005 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-006 IDLE: baud_clr=1; on a falling edge of rxd_s (previous 1, current 0), go to START with baud_clr=0 from the next cycle.
REQ-007 START, on half_pulse:
- rxd_s=0: start confirmed, remain in START.
- rxd_s=1: glitch; return to IDLE with no rx_valid and no frame_err.
REQ-008 START on done_pulse: go to DATA with bit index=0.
REQ-009 DATA on half_pulse: shift rxd_s into the MSB of the shift register (right shift), so that after DATA_BITS samples the first-received bit sits at bit 0.
REQ-010 DATA on done_pulse:
- bit index = DATA_BITS-1: go to STOP.
- otherwise: increment the bit index.
REQ-011 Bit index width SHALL be clog2(DATA_BITS); no wrap occurs because the index is cleared on entry to DATA.
REQ-012 STOP on half_pulse:
- rxd_s=1: load rx_data from the shift register and pulse rx_valid for exactly one cycle.
- rxd_s=0: pulse frame_err for one cycle and leave rx_data unchanged.
- In both cases: go to IDLE in the same cycle, so baud_clr rises and a following start bit is accepted without waiting for done_pulse.
REQ-013 half_pulse and done_pulse are never coincident; if both are asserted, half_pulse SHALL take priority and done_pulse is ignored.
REQ-014 Strobes arriving in IDLE SHALL be ignored.
REQ-015 rx_valid and frame_err SHALL never be asserted together.
REQ-016 Latency: rx_valid asserts on the cycle after half_pulse of the stop bit, i.e. 9.5 bit periods plus synchroniser delay after the start falling edge.
REQ-017 rxd held low after a frame (break condition): the falling-edge detector SHALL NOT retrigger until rxd_s has returned high.

Reset
REQ-018 On reset, SHALL set:
- state=IDLE, baud_clr=1, rx_data=0, rx_valid=0, frame_err=0, busy=0.
- shift register and bit index = 0.
- synchroniser flops = 1 (line idle), so release from reset never fakes a start edge.
REQ-019 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err pulse.

Structure
REQ-020 A shared package uart_pkg SHALL hold the state enumeration, DATA_BITS default, BAUD_DIV=1302 and HALF_BAUD=650.
REQ-021 The synchroniser SHALL be a separate sub-module rx_sync (parameter SYNC_STAGES, reset value 1); all other logic lives in uart_rx_ctrl.

Verification
(The bench instantiates the baud counter alongside uart_rx_ctrl, baud_clr wired to its reset; bit period 1302 clk.)
REQ-022 Frame 0xA5 with stop bit 1 -> one rx_valid pulse, rx_data=0xA5, frame_err never asserted.
REQ-023 Back-to-back frames 0x00 then 0xFF, the second start bit immediately after the stop bit -> two rx_valid pulses, rx_data 0x00 then 0xFF.
REQ-024 Frame 0x3C with stop bit 0 -> one frame_err pulse, no rx_valid, rx_data keeps its prior value.
REQ-025 rxd low glitch of 100 clk, then high -> return to IDLE at half_pulse, no output pulse, busy low afterwards.
REQ-026 reset asserted during data bit 4 of frame 0x55 -> all outputs at reset values next cycle; a subsequent frame 0x81 is received correctly.
